// File: rtl/rule_match_engine_if.sv
// Shared header types and the packet-in / result-out streaming interface
// used by rule_match_engine.
package rule_match_pkg;
   typedef struct packed {
      logic [31:0] ip;
      logic [15:0] port;
   } endpoint_s;

   typedef struct packed {
      logic [7:0] protocol;
      endpoint_s  src;
      endpoint_s  dst;
   } packet_s;

   typedef struct packed {
      packet_s start;
      packet_s last;
   } rule_s;
endpackage

interface rule_match_engine_if #(parameter int NUM_RULES = 16);
   import rule_match_pkg::*;
   localparam int IDX_W = $clog2(NUM_RULES);

   logic             in_valid;
   logic             in_ready;
   packet_s          in_packet;
   logic             out_valid;
   logic             out_ready;
   logic             out_hit;
   logic [IDX_W-1:0] out_idx;
   packet_s          out_packet;

   modport master (
      output in_valid, in_packet, out_ready,
      input  in_ready, out_valid, out_hit, out_idx, out_packet
   );

   modport slave (
      input  in_valid, in_packet, out_ready,
      output in_ready, out_valid, out_hit, out_idx, out_packet
   );
endinterface

// File: rtl/rule_match_engine.sv
// Multi-rule 5-tuple range classifier, 2-stage pipeline, lowest index wins.
// Optional per-rule saturating hit counters: define RULE_HIT_COUNT_EN.
module rule_match_engine
   import rule_match_pkg::*;
#(
   parameter int NUM_RULES = 16,
   parameter int COUNT_W   = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   rule_match_engine_if.slave           bus,
   input  logic                         rule_we,
   input  logic [$clog2(NUM_RULES)-1:0] rule_addr,
   input  rule_s                        rule_data,
   input  logic                         rule_en,
   input  logic                         rule_clear,
   input  logic [$clog2(NUM_RULES)-1:0] cnt_addr,
   output logic [COUNT_W-1:0]           cnt_data
);
   localparam int IDX_W = $clog2(NUM_RULES);

   rule_s                  rule_tab_r [NUM_RULES];
   logic [NUM_RULES-1:0]   rule_vld_r;
   logic [NUM_RULES-1:0]   match_vec_s;
   logic                   addr_ok_s;
   logic                   s2_advance_s;
   logic                   in_ready_s;
   logic                   s1_valid_r;
   packet_s                s1_packet_r;
   logic [NUM_RULES-1:0]   s1_match_r;
   logic                   out_valid_r;
   logic                   out_hit_r;
   logic [IDX_W-1:0]       out_idx_r;
   packet_s                out_packet_r;

   // A reversed range (start > last) on any field can never satisfy both bounds.
   function automatic logic rule_hit(input rule_s r, input packet_s p);
      return (p.protocol >= r.start.protocol) && (p.protocol <= r.last.protocol) &&
             (p.src.ip   >= r.start.src.ip)   && (p.src.ip   <= r.last.src.ip)   &&
             (p.src.port >= r.start.src.port) && (p.src.port <= r.last.src.port) &&
             (p.dst.ip   >= r.start.dst.ip)   && (p.dst.ip   <= r.last.dst.ip)   &&
             (p.dst.port >= r.start.dst.port) && (p.dst.port <= r.last.dst.port);
   endfunction

   function automatic logic [IDX_W-1:0] first_set(input logic [NUM_RULES-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = {IDX_W{1'b0}};
      for (int i = NUM_RULES - 1; i >= 0; i--) begin
         if (v[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   assign addr_ok_s    = (32'(rule_addr) < NUM_RULES);
   assign s2_advance_s = !out_valid_r || bus.out_ready;
   assign in_ready_s   = !s1_valid_r || s2_advance_s;

   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_hit    = out_hit_r;
   assign bus.out_idx    = out_idx_r;
   assign bus.out_packet = out_packet_r;

   // Parallel compare of the incoming header against every table entry.
   always_comb begin
      match_vec_s = {NUM_RULES{1'b0}};
      for (int i = 0; i < NUM_RULES; i++) begin
         match_vec_s[i] = rule_vld_r[i] && rule_hit(rule_tab_r[i], bus.in_packet);
      end
   end

   // Entry valid bits; clear beats a same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         rule_vld_r <= {NUM_RULES{1'b0}};
      end else if (rule_clear) begin
         rule_vld_r <= {NUM_RULES{1'b0}};
      end else if (rule_we && addr_ok_s) begin
         rule_vld_r[rule_addr] <= rule_en;
      end
   end

   // Range contents carry no reset; they are gated by the valid bits.
   always_ff @(posedge clk) begin
      if (rule_we && !rule_clear && addr_ok_s) begin
         rule_tab_r[rule_addr] <= rule_data;
      end
   end

   // Stage 1: capture packet and its match vector when the pipe can move.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r  <= 1'b0;
         s1_packet_r <= '0;
         s1_match_r  <= {NUM_RULES{1'b0}};
      end else if (in_ready_s) begin
         s1_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            s1_packet_r <= bus.in_packet;
            s1_match_r  <= match_vec_s;
         end
      end
   end

   // Stage 2: priority encode into the held result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r  <= 1'b0;
         out_hit_r    <= 1'b0;
         out_idx_r    <= {IDX_W{1'b0}};
         out_packet_r <= '0;
      end else if (s2_advance_s) begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            out_hit_r    <= |s1_match_r;
            out_idx_r    <= first_set(s1_match_r);
            out_packet_r <= s1_packet_r;
         end
      end
   end

`ifdef RULE_HIT_COUNT_EN
   logic [COUNT_W-1:0] cnt_r [NUM_RULES];
   logic               cnt_ok_s;

   // Saturating hit counters; an entry rewrite restarts its count.
   always_ff @(posedge clk) begin
      if (rst || rule_clear) begin
         for (int i = 0; i < NUM_RULES; i++) cnt_r[i] <= {COUNT_W{1'b0}};
      end else begin
         for (int i = 0; i < NUM_RULES; i++) begin
            if (rule_we && addr_ok_s && (rule_addr == IDX_W'(i))) begin
               cnt_r[i] <= {COUNT_W{1'b0}};
            end else if (out_valid_r && bus.out_ready && out_hit_r &&
                         (out_idx_r == IDX_W'(i)) && (cnt_r[i] != {COUNT_W{1'b1}})) begin
               cnt_r[i] <= cnt_r[i] + COUNT_W'(1);
            end
         end
      end
   end

   assign cnt_ok_s = (32'(cnt_addr) < NUM_RULES);
   assign cnt_data = cnt_ok_s ? cnt_r[cnt_addr] : {COUNT_W{1'b0}};
`else
   logic unused_cnt_addr_s;
   assign unused_cnt_addr_s = ^cnt_addr;
   assign cnt_data          = {COUNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_rule_match_engine.sv
// Randomized self-checking bench for rule_match_engine against a queue-based
// reference classifier.
module tb_rule_match_engine;
   import rule_match_pkg::*;

   localparam int NUM_RULES = 16;
   localparam int IDX_W     = 4;
   localparam int COUNT_W   = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               rule_we;
   logic [IDX_W-1:0]   rule_addr;
   rule_s              rule_data;
   logic               rule_en;
   logic               rule_clear;
   logic [IDX_W-1:0]   cnt_addr;
   logic [COUNT_W-1:0] cnt_data;

   always #5 clk = ~clk;

   rule_match_engine_if #(.NUM_RULES(NUM_RULES)) bus ();

   rule_match_engine #(.NUM_RULES(NUM_RULES), .COUNT_W(COUNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .rule_we    (rule_we),
      .rule_addr  (rule_addr),
      .rule_data  (rule_data),
      .rule_en    (rule_en),
      .rule_clear (rule_clear),
      .cnt_addr   (cnt_addr),
      .cnt_data   (cnt_data)
   );

   typedef struct {
      logic    hit;
      int      idx;
      packet_s pkt;
   } exp_t;

   int      errors = 0;
   int      checks = 0;
   rule_s   m_tab [NUM_RULES];
   bit      m_vld [NUM_RULES];
   int      m_cnt [NUM_RULES];
   exp_t    exp_q [$];
   bit      last_accept;
   bit      stall_prev;
   bit      saw_not_ready;
   logic    prev_hit;
   logic [IDX_W-1:0] prev_idx;
   packet_s prev_pkt;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit in_range(input longint v, input longint lo, input longint hi);
      return (lo <= v) && (v <= hi);
   endfunction

   // Reference: first valid entry whose every field range contains the header.
   function automatic exp_t classify(input packet_s p);
      exp_t e;
      e.hit = 1'b0;
      e.idx = 0;
      e.pkt = p;
      for (int i = 0; i < NUM_RULES; i++) begin
         if (m_vld[i] &&
             in_range(p.protocol, m_tab[i].start.protocol, m_tab[i].last.protocol) &&
             in_range(p.src.ip,   m_tab[i].start.src.ip,   m_tab[i].last.src.ip) &&
             in_range(p.src.port, m_tab[i].start.src.port, m_tab[i].last.src.port) &&
             in_range(p.dst.ip,   m_tab[i].start.dst.ip,   m_tab[i].last.dst.ip) &&
             in_range(p.dst.port, m_tab[i].start.dst.port, m_tab[i].last.dst.port)) begin
            e.hit = 1'b1;
            e.idx = i;
            return e;
         end
      end
      return e;
   endfunction

   // One clock: sample just after the negedge, update model, wait for next negedge.
   task automatic step();
      exp_t e;
      #1;
`ifdef RULE_HIT_COUNT_EN
      check("cnt_data", cnt_data, m_cnt[cnt_addr]);
`else
      check("cnt_data", cnt_data, 0);
`endif
      if (stall_prev) begin
         check("stall_valid", bus.out_valid, 1'b1);
         check("stall_hit", bus.out_hit, prev_hit);
         check("stall_idx", bus.out_idx, prev_idx);
         check("stall_pkt", bus.out_packet, prev_pkt);
      end
      if (!bus.in_ready) saw_not_ready = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
         check("out_expected", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_hit", bus.out_hit, e.hit);
            check("out_idx", bus.out_idx, e.idx);
            check("out_packet", bus.out_packet, e.pkt);
            if (e.hit && m_cnt[e.idx] < (1 << COUNT_W) - 1) m_cnt[e.idx]++;
         end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_hit   = bus.out_hit;
      prev_idx   = bus.out_idx;
      prev_pkt   = bus.out_packet;
      last_accept = bus.in_valid && bus.in_ready;
      if (last_accept) exp_q.push_back(classify(bus.in_packet));
      if (rule_clear) begin
         for (int i = 0; i < NUM_RULES; i++) begin
            m_vld[i] = 1'b0;
            m_cnt[i] = 0;
         end
      end else if (rule_we) begin
         m_tab[rule_addr] = rule_data;
         m_vld[rule_addr] = rule_en;
         m_cnt[rule_addr] = 0;
      end
      @(negedge clk);
   endtask

   function automatic rule_s full_rule();
      rule_s r;
      r.start = {$bits(packet_s){1'b0}};
      r.last  = {$bits(packet_s){1'b1}};
      return r;
   endfunction

   function automatic packet_s rand_pkt();
      packet_s p;
      p.protocol = 8'($urandom);
      p.src.ip   = 32'($urandom);
      p.src.port = 16'($urandom);
      p.dst.ip   = 32'($urandom);
      p.dst.port = 16'($urandom);
      return p;
   endfunction

   function automatic packet_s small_pkt();
      packet_s p;
      p.protocol = 8'($urandom_range(0, 3));
      p.src.ip   = 32'($urandom_range(0, 7));
      p.src.port = 16'($urandom_range(0, 7));
      p.dst.ip   = 32'($urandom_range(0, 7));
      p.dst.port = 16'($urandom_range(0, 7));
      return p;
   endfunction

   function automatic rule_s small_rule();
      rule_s r;
      r.start.protocol = 8'($urandom_range(0, 2));
      r.last.protocol  = 8'($urandom_range(1, 3));
      r.start.src.ip   = 32'($urandom_range(0, 5));
      r.last.src.ip    = 32'($urandom_range(2, 7));
      r.start.src.port = 16'($urandom_range(0, 5));
      r.last.src.port  = 16'($urandom_range(2, 7));
      r.start.dst.ip   = 32'($urandom_range(0, 5));
      r.last.dst.ip    = 32'($urandom_range(2, 7));
      r.start.dst.port = 16'($urandom_range(0, 5));
      r.last.dst.port  = 16'($urandom_range(2, 7));
      return r;
   endfunction

   task automatic wr(input int addr, input rule_s r, input logic en);
      rule_we   = 1'b1;
      rule_addr = IDX_W'(addr);
      rule_data = r;
      rule_en   = en;
      step();
      rule_we   = 1'b0;
   endtask

   task automatic clear_tab();
      rule_clear = 1'b1;
      step();
      rule_clear = 1'b0;
   endtask

   task automatic send(input packet_s p);
      bus.in_valid  = 1'b1;
      bus.in_packet = p;
      for (int k = 0; k < 50; k++) begin
         step();
         if (last_accept) break;
      end
      check("send_accepted", last_accept, 1'b1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic install_3_7();
      rule_s r;
      r = full_rule();
      r.start.dst.port = 16'd80;
      r.last.dst.port  = 16'd80;
      wr(3, r, 1'b1);
      wr(7, full_rule(), 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      packet_s p;
      rule_s   r;
      int      sent;
      rst           = 1'b1;
      rule_we       = 1'b0;
      rule_addr     = {IDX_W{1'b0}};
      rule_data     = full_rule();
      rule_en       = 1'b0;
      rule_clear    = 1'b0;
      cnt_addr      = {IDX_W{1'b0}};
      bus.in_valid  = 1'b0;
      bus.in_packet = '0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NUM_RULES; i++) begin
         m_vld[i] = 1'b0;
         m_cnt[i] = 0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_hit", bus.out_hit, 1'b0);
      check("rst_out_idx", bus.out_idx, 0);
      check("rst_out_packet", bus.out_packet, 0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_cnt", cnt_data, 0);
      @(negedge clk);

      // Empty table: latency of two and a miss with index 0.
      p = rand_pkt();
      p.protocol = 8'd6;
      bus.in_valid  = 1'b1;
      bus.in_packet = p;
      step();
      check("t1_accept", last_accept, 1'b1);
      bus.in_valid = 1'b0;
      check("t1_lat1_valid", bus.out_valid, 1'b0);
      step();
      check("t1_lat2_valid", bus.out_valid, 1'b1);
      check("t1_hit", bus.out_hit, 1'b0);
      check("t1_idx", bus.out_idx, 0);
      drain();

      // Exact-port rule beats the catch-all only when the port matches.
      install_3_7();
      foreach (p.protocol[i]) ;
      for (int k = 0; k < 3; k++) begin
         p = rand_pkt();
         p.dst.port = (k == 0) ? 16'd80 : (k == 1) ? 16'd81 : 16'd79;
         send(p);
      end
      drain();

      // Inclusive address bounds and a reversed port range.
      clear_tab();
      r = full_rule();
      r.start.src.ip = 32'h0A00_0000;
      r.last.src.ip  = 32'h0A00_00FF;
      wr(0, r, 1'b1);
      r = full_rule();
      r.start.src.port = 16'd100;
      r.last.src.port  = 16'd50;
      wr(5, r, 1'b1);
      for (int k = 0; k < 5; k++) begin
         p = rand_pkt();
         p.src.ip = (k == 0) ? 32'h0A00_0000 : (k == 1) ? 32'h0A00_00FF :
                    (k == 2) ? 32'h09FF_FFFF : (k == 3) ? 32'h0A00_0100 : 32'h0B00_0000;
         if (k == 4) p.src.port = 16'd75;
         send(p);
      end
      drain();

      // Back-to-back burst with a four-cycle downstream stall.
      clear_tab();
      install_3_7();
      sent = 0;
      saw_not_ready = 1'b0;
      p = rand_pkt();
      p.dst.port = 16'($urandom_range(78, 82));
      for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
         bus.out_ready = !(c >= 3 && c <= 6);
         bus.in_valid  = (sent < 8);
         bus.in_packet = p;
         step();
         if (last_accept) begin
            sent++;
            p = rand_pkt();
            p.dst.port = 16'($urandom_range(78, 82));
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("t4_sent", sent, 8);
      check("t4_in_ready_drop", saw_not_ready, 1'b1);
      check("t4_queue_empty", exp_q.size(), 0);

      // Delete in the accept cycle; clear beats a same-cycle write.
      p = rand_pkt();
      p.dst.port    = 16'd80;
      bus.in_valid  = 1'b1;
      bus.in_packet = p;
      rule_we   = 1'b1;
      rule_addr = IDX_W'(3);
      rule_data = full_rule();
      rule_en   = 1'b0;
      step();
      check("t5_accept", last_accept, 1'b1);
      rule_we      = 1'b0;
      bus.in_valid = 1'b0;
      p = rand_pkt();
      p.dst.port = 16'd80;
      send(p);
      rule_clear = 1'b1;
      rule_we    = 1'b1;
      rule_addr  = IDX_W'(1);
      rule_data  = full_rule();
      rule_en    = 1'b1;
      step();
      rule_clear = 1'b0;
      rule_we    = 1'b0;
      send(rand_pkt());
      drain();

      // Hit counter saturation and clear.
      clear_tab();
      wr(2, full_rule(), 1'b1);
      cnt_addr = IDX_W'(2);
      for (int k = 0; k < 20; k++) send(rand_pkt());
      drain();
`ifdef RULE_HIT_COUNT_EN
      check("t6_cnt_sat", cnt_data, 15);
`else
      check("t6_cnt_sat", cnt_data, 0);
`endif
      clear_tab();
      check("t6_cnt_cleared", cnt_data, 0);

      // Random traffic, table churn and backpressure.
      bus.in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!bus.in_valid || last_accept) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_packet = small_pkt();
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cnt_addr      = IDX_W'($urandom);
         rule_clear    = ($urandom_range(0, 99) == 0);
         rule_we       = ($urandom_range(0, 5) == 0);
         rule_addr     = IDX_W'($urandom);
         rule_data     = small_rule();
         rule_en       = ($urandom_range(0, 4) != 0);
         step();
      end
      rule_we    = 1'b0;
      rule_clear = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
